// File: rtl/branch_hazard_sequencer_if.sv
// Decode-stage branch sequencer bundle: pipeline (master) drives hazard/branch
// context, the sequencer (slave) returns stall, flush, forward and counter outputs.
interface branch_hazard_sequencer_if #(
   parameter int CNT_W = 32
);
   logic             BranchD;
   logic             UsesRsD;
   logic             UsesRtD;
   logic [4:0]       RsD;
   logic [4:0]       RtD;
   logic             RegWriteE;
   logic             MemtoRegE;
   logic [4:0]       WriteRegE;
   logic             RegWriteM;
   logic             MemtoRegM;
   logic [4:0]       WriteRegM;
   logic [1:0]       PCSrcD;
   logic             StallExt;
   logic [1:0]       PCSrcF;
   logic             StallF;
   logic             StallD;
   logic             FlushD;
   logic             FlushE;
   logic             ForwardAD;
   logic             ForwardBD;
   logic [CNT_W-1:0] BranchCnt;
   logic [CNT_W-1:0] TakenCnt;
   logic [CNT_W-1:0] StallCnt;

   modport master (
      output BranchD, UsesRsD, UsesRtD, RsD, RtD,
             RegWriteE, MemtoRegE, WriteRegE,
             RegWriteM, MemtoRegM, WriteRegM,
             PCSrcD, StallExt,
      input  PCSrcF, StallF, StallD, FlushD, FlushE,
             ForwardAD, ForwardBD, BranchCnt, TakenCnt, StallCnt
   );

   modport slave (
      input  BranchD, UsesRsD, UsesRtD, RsD, RtD,
             RegWriteE, MemtoRegE, WriteRegE,
             RegWriteM, MemtoRegM, WriteRegM,
             PCSrcD, StallExt,
      output PCSrcF, StallF, StallD, FlushD, FlushE,
             ForwardAD, ForwardBD, BranchCnt, TakenCnt, StallCnt
   );
endinterface

// File: rtl/branch_hazard_sequencer.sv
// Decode-stage branch sequencer: stalls a hazarded branch for exactly N cycles,
// gates the redirect, selects D-stage forwarding and counts branch events.
module branch_hazard_sequencer #(
   parameter bit DELAY_SLOT = 1'b0,
   parameter int CNT_W      = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   branch_hazard_sequencer_if.slave  bus
);

   typedef enum logic {IDLE, STALL} state_e;

   state_e           state_q, state_d;
   logic             cnt_q, cnt_d;
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic       rs_e, rt_e, rs_m, rt_m;
   logic [1:0] n_rs, n_rt, n_need;
   logic       stall, resolve;

   assign rs_e = bus.UsesRsD & bus.RegWriteE & (bus.WriteRegE == bus.RsD) & (bus.RsD != 5'd0);
   assign rt_e = bus.UsesRtD & bus.RegWriteE & (bus.WriteRegE == bus.RtD) & (bus.RtD != 5'd0);
   assign rs_m = bus.UsesRsD & bus.RegWriteM & (bus.WriteRegM == bus.RsD) & (bus.RsD != 5'd0);
   assign rt_m = bus.UsesRtD & bus.RegWriteM & (bus.WriteRegM == bus.RtD) & (bus.RtD != 5'd0);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      n_rs = 2'd0;
      n_rt = 2'd0;
      if (rs_e)                      n_rs = bus.MemtoRegE ? 2'd2 : 2'd1;
      else if (rs_m & bus.MemtoRegM) n_rs = 2'd1;
      if (rt_e)                      n_rt = bus.MemtoRegE ? 2'd2 : 2'd1;
      else if (rt_m & bus.MemtoRegM) n_rt = 2'd1;
      n_need = (n_rs > n_rt) ? n_rs : n_rt;
   end

   // cnt holds the stall cycles still owed after the current one; STALL with cnt 0 is the resolve cycle.
   assign stall   = ((state_q == IDLE) & bus.BranchD & (n_need != 2'd0))
                  | ((state_q == STALL) & (cnt_q != 1'b0));
   assign resolve = bus.BranchD & ~stall & ~bus.StallExt;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.BranchD && (n_need != 2'd0) && !bus.StallExt) begin
               state_d = STALL;
               cnt_d   = (n_need == 2'd2);
            end
         end
         STALL: begin
            if (!bus.StallExt) begin
               if (cnt_q == 1'b0) state_d = IDLE;
               else               cnt_d   = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 1'b0;
         end
      endcase
   end

   always_comb begin
      branch_cnt_d = branch_cnt_q;
      taken_cnt_d  = taken_cnt_q;
      stall_cnt_d  = stall_cnt_q;
      if (resolve && (branch_cnt_q != '1))
         branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (resolve && (bus.PCSrcD != 2'b00) && (taken_cnt_q != '1))
         taken_cnt_d = taken_cnt_q + CNT_W'(1);
      if (stall && !bus.StallExt && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= 1'b0;
         branch_cnt_q <= '0;
         taken_cnt_q  <= '0;
         stall_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         branch_cnt_q <= branch_cnt_d;
         taken_cnt_q  <= taken_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign bus.PCSrcF    = stall ? 2'b00 : bus.PCSrcD;
   assign bus.StallF    = stall;
   assign bus.StallD    = stall;
   assign bus.FlushE    = stall;
   assign bus.FlushD    = ~DELAY_SLOT & ~stall & ~bus.StallExt & (bus.PCSrcF != 2'b00);
   assign bus.ForwardAD = rs_m & ~bus.MemtoRegM;
   assign bus.ForwardBD = rt_m & ~bus.MemtoRegM;
   assign bus.BranchCnt = branch_cnt_q;
   assign bus.TakenCnt  = taken_cnt_q;
   assign bus.StallCnt  = stall_cnt_q;

endmodule

// File: tb/tb_branch_hazard_sequencer.sv
// Directed bench for branch_hazard_sequencer: dut0 has no delay slot and 32-bit
// counters, dut1 mirrors the same inputs with a delay slot and 2-bit counters.
module tb_branch_hazard_sequencer;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   branch_hazard_sequencer_if #(.CNT_W(32)) if0 ();
   branch_hazard_sequencer_if #(.CNT_W(2))  if1 ();

   branch_hazard_sequencer #(.DELAY_SLOT(1'b0), .CNT_W(32)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (if0)
   );

   branch_hazard_sequencer #(.DELAY_SLOT(1'b1), .CNT_W(2)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (if1)
   );

   assign if1.BranchD   = if0.BranchD;
   assign if1.UsesRsD   = if0.UsesRsD;
   assign if1.UsesRtD   = if0.UsesRtD;
   assign if1.RsD       = if0.RsD;
   assign if1.RtD       = if0.RtD;
   assign if1.RegWriteE = if0.RegWriteE;
   assign if1.MemtoRegE = if0.MemtoRegE;
   assign if1.WriteRegE = if0.WriteRegE;
   assign if1.RegWriteM = if0.RegWriteM;
   assign if1.MemtoRegM = if0.MemtoRegM;
   assign if1.WriteRegM = if0.WriteRegM;
   assign if1.PCSrcD    = if0.PCSrcD;
   assign if1.StallExt  = if0.StallExt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge, apply one vector, let combinational outputs settle.
   task automatic drive(input logic b, input logic urs, input logic urt,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic rwe, input logic mte, input logic [4:0] wre,
                        input logic rwm, input logic mtm, input logic [4:0] wrm,
                        input logic [1:0] pc, input logic ext);
      @(negedge clk);
      if0.BranchD   = b;
      if0.UsesRsD   = urs;
      if0.UsesRtD   = urt;
      if0.RsD       = rs;
      if0.RtD       = rt;
      if0.RegWriteE = rwe;
      if0.MemtoRegE = mte;
      if0.WriteRegE = wre;
      if0.RegWriteM = rwm;
      if0.MemtoRegM = mtm;
      if0.WriteRegM = wrm;
      if0.PCSrcD    = pc;
      if0.StallExt  = ext;
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 2'b00, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_stall(input string tag, input logic exp);
      check({tag, "_StallF"}, {31'd0, if0.StallF}, {31'd0, exp});
      check({tag, "_StallD"}, {31'd0, if0.StallD}, {31'd0, exp});
      check({tag, "_FlushE"}, {31'd0, if0.FlushE}, {31'd0, exp});
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      idle();
      idle();
      reset = 1'b0;
      idle();

      // reset state, BranchD low
      check_stall("rst", 1'b0);
      check("rst_PCSrcF", {30'd0, if0.PCSrcF}, 32'd0);
      check("rst_FlushD", {31'd0, if0.FlushD}, 32'd0);
      check("rst_FwdA", {31'd0, if0.ForwardAD}, 32'd0);
      check("rst_BranchCnt", if0.BranchCnt, 32'd0);
      check("rst_TakenCnt", if0.TakenCnt, 32'd0);
      check("rst_StallCnt", if0.StallCnt, 32'd0);

      // 1: beq $5, no producers, taken
      drive(1, 1, 1, 5'd5, 5'd6, 0, 0, 5'd0, 0, 0, 5'd0, 2'b01, 0);
      check_stall("t1", 1'b0);
      check("t1_PCSrcF", {30'd0, if0.PCSrcF}, 32'd1);
      check("t1_FlushD", {31'd0, if0.FlushD}, 32'd1);
      check("t1_FlushD_ds", {31'd0, if1.FlushD}, 32'd0);
      idle();
      check("t1_BranchCnt", if0.BranchCnt, 32'd1);
      check("t1_TakenCnt", if0.TakenCnt, 32'd1);
      check("t1_StallCnt", if0.StallCnt, 32'd0);

      // 2: lw $8 in EX, beq $8 -> two stall cycles
      do_reset();
      drive(1, 1, 1, 5'd8, 5'd9, 1, 1, 5'd8, 0, 0, 5'd0, 2'b01, 0);
      check_stall("t2_c1", 1'b1);
      check("t2_c1_PCSrcF", {30'd0, if0.PCSrcF}, 32'd0);
      check("t2_c1_FlushD", {31'd0, if0.FlushD}, 32'd0);
      drive(1, 1, 1, 5'd8, 5'd9, 0, 0, 5'd0, 1, 1, 5'd8, 2'b01, 0);
      check_stall("t2_c2", 1'b1);
      check("t2_c2_PCSrcF", {30'd0, if0.PCSrcF}, 32'd0);
      check("t2_c2_FwdA", {31'd0, if0.ForwardAD}, 32'd0);
      drive(1, 1, 1, 5'd8, 5'd9, 0, 0, 5'd0, 0, 0, 5'd0, 2'b01, 0);
      check_stall("t2_c3", 1'b0);
      check("t2_c3_PCSrcF", {30'd0, if0.PCSrcF}, 32'd1);
      check("t2_c3_FlushD", {31'd0, if0.FlushD}, 32'd1);
      idle();
      check("t2_StallCnt", if0.StallCnt, 32'd2);
      check("t2_BranchCnt", if0.BranchCnt, 32'd1);
      check("t2_TakenCnt", if0.TakenCnt, 32'd1);

      // 3: add $9 in EX, bne on rt=$9 -> one stall, then forward from MEM
      do_reset();
      drive(1, 1, 1, 5'd4, 5'd9, 1, 0, 5'd9, 0, 0, 5'd0, 2'b01, 0);
      check_stall("t3_c1", 1'b1);
      check("t3_c1_PCSrcF", {30'd0, if0.PCSrcF}, 32'd0);
      drive(1, 1, 1, 5'd4, 5'd9, 0, 0, 5'd0, 1, 0, 5'd9, 2'b01, 0);
      check_stall("t3_c2", 1'b0);
      check("t3_c2_FwdB", {31'd0, if0.ForwardBD}, 32'd1);
      check("t3_c2_FwdA", {31'd0, if0.ForwardAD}, 32'd0);
      check("t3_c2_PCSrcF", {30'd0, if0.PCSrcF}, 32'd1);
      idle();
      check("t3_StallCnt", if0.StallCnt, 32'd1);
      check("t3_BranchCnt", if0.BranchCnt, 32'd1);

      // 4: lw hazard with a 3-cycle external freeze after the first stall
      do_reset();
      drive(1, 1, 1, 5'd8, 5'd9, 1, 1, 5'd8, 0, 0, 5'd0, 2'b01, 0);
      check_stall("t4_c1", 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 1, 5'd8, 5'd9, 0, 0, 5'd0, 1, 1, 5'd8, 2'b01, 1);
         check_stall("t4_frz", 1'b1);
         check("t4_frz_FlushD", {31'd0, if0.FlushD}, 32'd0);
         check("t4_frz_StallCnt", if0.StallCnt, 32'd1);
      end
      drive(1, 1, 1, 5'd8, 5'd9, 0, 0, 5'd0, 1, 1, 5'd8, 2'b01, 0);
      check_stall("t4_c2", 1'b1);
      drive(1, 1, 1, 5'd8, 5'd9, 0, 0, 5'd0, 0, 0, 5'd0, 2'b01, 0);
      check_stall("t4_c3", 1'b0);
      check("t4_c3_PCSrcF", {30'd0, if0.PCSrcF}, 32'd1);
      idle();
      check("t4_StallCnt", if0.StallCnt, 32'd2);
      check("t4_BranchCnt", if0.BranchCnt, 32'd1);

      // 5: reset while in STALL with one cycle still owed
      do_reset();
      drive(1, 1, 1, 5'd8, 5'd9, 1, 1, 5'd8, 0, 0, 5'd0, 2'b01, 0);
      check_stall("t5_c1", 1'b1);
      @(negedge clk);
      reset = 1'b1;
      if0.BranchD  = 1'b0;
      if0.PCSrcD   = 2'b00;
      if0.RegWriteE = 1'b0;
      if0.MemtoRegE = 1'b0;
      idle();
      reset = 1'b0;
      #1;
      check_stall("t5_rst", 1'b0);
      check("t5_PCSrcF", {30'd0, if0.PCSrcF}, 32'd0);
      check("t5_StallCnt", if0.StallCnt, 32'd0);
      idle();
      check_stall("t5_after", 1'b0);
      check("t5_after_StallCnt", if0.StallCnt, 32'd0);

      // 6: jr $0 while EX writes $0 -> no hazard
      do_reset();
      drive(1, 1, 0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 5'd0, 2'b11, 0);
      check_stall("t6", 1'b0);
      check("t6_PCSrcF", {30'd0, if0.PCSrcF}, 32'd3);
      check("t6_FlushD", {31'd0, if0.FlushD}, 32'd1);
      check("t6_FlushD_ds", {31'd0, if1.FlushD}, 32'd0);
      idle();
      check("t6_TakenCnt", if0.TakenCnt, 32'd1);

      // j ignores a matching load in EX because no operand is used
      drive(1, 0, 0, 5'd8, 5'd8, 1, 1, 5'd8, 0, 0, 5'd0, 2'b10, 0);
      check_stall("t7_j", 1'b0);
      check("t7_PCSrcF", {30'd0, if0.PCSrcF}, 32'd2);

      // both operands hazarded (load in EX on rs, load in MEM on rt): max, not sum
      do_reset();
      drive(1, 1, 1, 5'd8, 5'd9, 1, 1, 5'd8, 1, 1, 5'd9, 2'b01, 0);
      check_stall("t8_c1", 1'b1);
      drive(1, 1, 1, 5'd8, 5'd9, 0, 0, 5'd0, 1, 1, 5'd8, 2'b01, 0);
      check_stall("t8_c2", 1'b1);
      drive(1, 1, 1, 5'd8, 5'd9, 0, 0, 5'd0, 0, 0, 5'd0, 2'b01, 0);
      check_stall("t8_c3", 1'b0);
      idle();
      check("t8_StallCnt", if0.StallCnt, 32'd2);

      // not-taken branch counts as resolved but not taken; no flush
      do_reset();
      drive(1, 1, 1, 5'd3, 5'd4, 0, 0, 5'd0, 0, 0, 5'd0, 2'b00, 0);
      check("t9_FlushD", {31'd0, if0.FlushD}, 32'd0);
      idle();
      check("t9_BranchCnt", if0.BranchCnt, 32'd1);
      check("t9_TakenCnt", if0.TakenCnt, 32'd0);

      // saturation: five taken branches, dut1 counters are 2 bits wide
      do_reset();
      for (int i = 0; i < 5; i++)
         drive(1, 1, 1, 5'd3, 5'd4, 0, 0, 5'd0, 0, 0, 5'd0, 2'b01, 0);
      idle();
      check("sat_BranchCnt_w32", if0.BranchCnt, 32'd5);
      check("sat_BranchCnt_w2", {30'd0, if1.BranchCnt}, 32'd3);
      check("sat_TakenCnt_w2", {30'd0, if1.TakenCnt}, 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
